// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with occupancy count,
// programmable almost-full / almost-empty flags and overflow / underflow pulses.
//
// Optional build macro: FIFO_FWFT_EN
//   undefined : data_out is registered and updates one edge after an accepted read
//   defined   : first-word-fall-through; data_out shows the head word while
//               ready=1 (0 when empty) and okuma_cs pops it
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   okuma_cs     in   read request (pop)
//   yazma_cs     in   write request (push)
//   data_in      in   [WIDTH-1:0] write data
//   data_out     out  [WIDTH-1:0] read data
//   ready        out  FIFO not empty
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  [AW:0] occupancy 0..DEPTH
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
//
// Handshake: a request is sampled on every rising edge while its *_cs is high.
// A write is accepted when the FIFO is not full, or when a read is accepted
// on the same edge. A read is accepted when the FIFO is not empty. Requests
// that are not accepted have no effect other than the matching error pulse on
// the following cycle; there is no back-pressure stall, so a rejected request
// is simply lost.

module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             okuma_cs,
  input  logic             yazma_cs,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // Flags are decoded from the registered count only.
  assign ready        = (count != '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A read frees a slot on the same edge, so a full FIFO can still take a
  // write when it is paired with a read.
  assign rd_acc = okuma_cs && ready;
  assign wr_acc = yazma_cs && (!full || rd_acc);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      overflow  <= yazma_cs && !wr_acc;
      underflow <= okuma_cs && !rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible as soon as count says it exists.
  assign data_out = ready ? mem[rd_ptr] : '0;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
`timescale 1ns/1ps
module tb_param_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          okuma_cs = 1'b0;
  logic          yazma_cs = 1'b0;
  logic [W-1:0]  data_in  = '0;
  logic [W-1:0]  data_out;
  logic          ready, full, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .okuma_cs(okuma_cs), .yazma_cs(yazma_cs),
    .data_in(data_in), .data_out(data_out), .ready(ready), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dout = '0;
  bit           m_ovf  = 1'b0;
  bit           m_udf  = 1'b0;
  bit           rd_ok, wr_ok;
  logic [W-1:0] popped;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      rd_ok = okuma_cs && (exp_q.size() > 0);
      wr_ok = yazma_cs && ((exp_q.size() < DEPTH) || rd_ok);
      m_ovf = yazma_cs && !wr_ok;
      m_udf = okuma_cs && !rd_ok;
      if (rd_ok) begin
        popped = exp_q.pop_front();
        m_dout = popped;
      end
      if (wr_ok) exp_q.push_back(data_in);
    end
  end

  function automatic logic [W-1:0] model_dout();
`ifdef FIFO_FWFT_EN
    return (exp_q.size() > 0) ? exp_q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count", 32'(count), 32'(exp_q.size()));
      check("cmp_ready", 32'(ready), 32'(exp_q.size() != 0));
      check("cmp_full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("cmp_almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
      check("cmp_almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
      check("cmp_data_out", 32'(data_out), 32'(model_dout()));
      check("cmp_overflow", 32'(overflow), 32'(m_ovf));
      check("cmp_underflow", 32'(underflow), 32'(m_udf));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; inputs are held across the next rising edge.
  task automatic do_cycle(input logic rd, input logic wr, input logic [W-1:0] d);
    okuma_cs = rd;
    yazma_cs = wr;
    data_in  = d;
    @(posedge clk);
    #1;
    okuma_cs = 1'b0;
    yazma_cs = 1'b0;
  endtask

  // Pops one word and checks it where it is visible in the current mode.
  task automatic read_word(input logic wr, input logic [W-1:0] wd,
                           input logic [W-1:0] exp, input string nm);
`ifdef FIFO_FWFT_EN
    check(nm, 32'(data_out), 32'(exp));
    do_cycle(1'b1, wr, wd);
`else
    do_cycle(1'b1, wr, wd);
    check(nm, 32'(data_out), 32'(exp));
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  logic [W-1:0] d;
  int wr_pct, rd_pct;

  initial begin
    // reset then idle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_almost_empty", 32'(almost_empty), 1);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_full", 32'(full), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    chk_en = 1'b1;
    release_reset();

    // fill C0..CF
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'hC0 + 8'(i);
      do_cycle(1'b0, 1'b1, d);
`ifdef FIFO_FWFT_EN
      if (i == 0) check("fwft_first_word", 32'(data_out), 32'h0C0);
`endif
      if (i == 12) check("fill_af_low_13", 32'(almost_full), 0);
      if (i == 13) check("fill_af_high_14", 32'(almost_full), 1);
    end
    check("fill_count", 32'(count), 16);
    check("fill_full", 32'(full), 1);
    check("model_size_full", 32'(exp_q.size()), 16);
    do_cycle(1'b0, 1'b1, 8'hD0);
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    do_cycle(1'b0, 1'b0, '0);
    check("ovf_one_cycle", 32'(overflow), 0);

    // drain
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'hC0 + 8'(i);
      read_word(1'b0, '0, d, "drain_data");
    end
    do_cycle(1'b1, 1'b0, '0);
    check("udf_pulse", 32'(underflow), 1);
    check("udf_ready", 32'(ready), 0);
`ifdef FIFO_FWFT_EN
    check("udf_data_out", 32'(data_out), 0);
`else
    check("udf_data_out", 32'(data_out), 32'h0CF);
`endif
    do_cycle(1'b0, 1'b0, '0);
    check("udf_one_cycle", 32'(underflow), 0);

    // wrap with concurrent access
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 8'hC0 + 8'(i));
    for (int i = 0; i < 14; i++) begin
      read_word(1'b1, 8'hC6 + 8'(i), 8'hC0 + 8'(i), "wrap_data");
      check("wrap_count", 32'(count), 6);
      check("wrap_no_ovf", 32'(overflow), 0);
      check("wrap_no_udf", 32'(underflow), 0);
    end
    for (int i = 0; i < 6; i++) read_word(1'b0, '0, 8'hCE + 8'(i), "wrap_tail");
    check("wrap_empty", 32'(count), 0);

    // full plus simultaneous read+write
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'h10 + 8'(i));
    read_word(1'b1, 8'hE0, 8'h10, "fullrw_first");
    check("fullrw_no_ovf", 32'(overflow), 0);
    check("fullrw_count", 32'(count), 16);
    for (int i = 1; i < DEPTH; i++) read_word(1'b0, '0, 8'h10 + 8'(i), "fullrw_data");
    read_word(1'b0, '0, 8'hE0, "fullrw_e0_last");
    check("fullrw_empty", 32'(count), 0);

    // reset mid-operation
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 8'hA0 + 8'(i));
    check("mid_count5", 32'(count), 5);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_data_out", 32'(data_out), 0);
    check("mid_rst_ready", 32'(ready), 0);
    check("model_size_rst", 32'(exp_q.size()), 0);
    release_reset();
    do_cycle(1'b1, 1'b0, '0);
    check("mid_post_udf", 32'(underflow), 1);

    // randomized traffic with occasional asynchronous resets
    for (int seg = 0; seg < 12; seg++) begin
      wr_pct = $urandom_range(10, 90);
      rd_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          #2 rst = 1'b0;
          #4 rst = 1'b1;
          @(posedge clk);
          #1;
        end else begin
          do_cycle(1'($urandom_range(0, 99) < rd_pct),
                   1'($urandom_range(0, 99) < wr_pct),
                   W'($urandom));
        end
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
